// File: rtl/xbar_out_scheduler_pkg.sv
// Shared constants and per-output arbiter state encoding for the crossbar scheduler.
package xbar_out_scheduler_pkg;

  localparam int NUM_PORTS = 14;
  localparam int PORT_W    = 4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/xbar_out_scheduler_rr_out_arbiter.sv
// One output port's round-robin arbiter: picks among candidate inputs and holds the
// winner until its end-of-packet beat moves.
module rr_out_arbiter
  import xbar_out_scheduler_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] cand,
  input  logic [NUM_PORTS-1:0] req_valid,
  input  logic [NUM_PORTS-1:0] req_eop,
  input  logic                 out_ready,
  output logic [PORT_W-1:0]    sel,
  output logic                 sel_valid,
  output logic                 xfer
);

  arb_state_e        state;
  arb_state_e        state_nxt;
  logic [PORT_W-1:0] ptr;
  logic [PORT_W-1:0] ptr_nxt;
  logic [PORT_W-1:0] sel_nxt;
  logic              win_found;
  logic [PORT_W-1:0] win_idx;

  // Scan starts just past the last winner so that input gets lowest priority next.
  always_comb begin
    logic [PORT_W:0] pos;
    win_found = 1'b0;
    win_idx   = '0;
    pos       = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      pos = {1'b0, ptr} + (PORT_W+1)'(k);
      if (pos >= (PORT_W+1)'(NUM_PORTS))
        pos = pos - (PORT_W+1)'(NUM_PORTS);
      if (!win_found && cand[pos[PORT_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = pos[PORT_W-1:0];
      end
    end
  end

  assign sel_valid = (state == ST_LOCKED);
  assign xfer      = sel_valid && req_valid[sel] && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      sel   <= '0;
      ptr   <= PORT_W'(NUM_PORTS - 1);
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    ptr_nxt   = ptr;
    case (state)
      ST_IDLE: begin
        if (win_found) begin
          state_nxt = ST_LOCKED;
          sel_nxt   = win_idx;
        end
      end
      ST_LOCKED: begin
        // Lock follows the registered sel only; req_dest changes are ignored here.
        if (xfer && req_eop[sel]) begin
          state_nxt = ST_IDLE;
          ptr_nxt   = sel;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/xbar_out_scheduler.sv
// Packet-granular crossbar scheduler: one round-robin arbiter per output, with an
// input-side lock mask so each input is bound to at most one output at a time.
module xbar_out_scheduler
  import xbar_out_scheduler_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req_valid,
  input  logic [NUM_PORTS*PORT_W-1:0] req_dest,
  input  logic [NUM_PORTS-1:0]        req_eop,
  input  logic [NUM_PORTS-1:0]        out_ready,
  output logic [NUM_PORTS-1:0]        grant,
  output logic [NUM_PORTS*PORT_W-1:0] out_sel,
  output logic [NUM_PORTS-1:0]        out_sel_valid,
  output logic [NUM_PORTS-1:0]        out_xfer
);

  logic [PORT_W-1:0]    sel_arr [NUM_PORTS];
  logic [NUM_PORTS-1:0] sel_vld;
  logic [NUM_PORTS-1:0] xfer_vec;
  logic [NUM_PORTS-1:0] in_locked;
  logic [NUM_PORTS-1:0] cand [NUM_PORTS];

  always_comb begin
    in_locked = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (sel_vld[o] && (sel_arr[o] == PORT_W'(i)))
          in_locked[i] = 1'b1;
      end
    end
  end

  // Excluding already-locked inputs is what keeps two outputs from owning one input.
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      cand[o] = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        cand[o][i] = req_valid[i] && !in_locked[i] &&
                     (req_dest[i*PORT_W +: PORT_W] == PORT_W'(o));
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (sel_vld[o] && out_ready[o] && (sel_arr[o] == PORT_W'(i)))
          grant[i] = 1'b1;
      end
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    rr_out_arbiter u_arb (
      .clk       (clk),
      .rst       (rst),
      .cand      (cand[o]),
      .req_valid (req_valid),
      .req_eop   (req_eop),
      .out_ready (out_ready[o]),
      .sel       (sel_arr[o]),
      .sel_valid (sel_vld[o]),
      .xfer      (xfer_vec[o])
    );
    assign out_sel[o*PORT_W +: PORT_W] = sel_arr[o];
  end

  assign out_sel_valid = sel_vld;
  assign out_xfer      = xfer_vec;

endmodule

// File: tb/tb_xbar_out_scheduler.sv
// Bench for xbar_out_scheduler: directed scenarios plus random traffic, all checked
// against a packet-level reference model of the per-output locks and priority pointers.
module tb_xbar_out_scheduler;
  import xbar_out_scheduler_pkg::*;

  localparam int N = NUM_PORTS;
  localparam int W = PORT_W;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N*W-1:0] req_dest = '0;
  logic [N-1:0] req_eop = '0;
  logic [N-1:0] out_ready = '0;
  logic [N-1:0] grant;
  logic [N*W-1:0] out_sel;
  logic [N-1:0] out_sel_valid;
  logic [N-1:0] out_xfer;

  xbar_out_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_dest      (req_dest),
    .req_eop       (req_eop),
    .out_ready     (out_ready),
    .grant         (grant),
    .out_sel       (out_sel),
    .out_sel_valid (out_sel_valid),
    .out_xfer      (out_xfer)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: which input each output owns (-1 = free) and who won last.
  int m_lock [N];
  int m_ptr  [N];
  logic [N-1:0]   exp_grant, exp_vld, exp_xfer;
  logic [N*W-1:0] exp_sel;

  // Upstream packet sources: beats left in the current packet and its destination.
  int pk_left [N];
  int pk_dest [N];

  function automatic int dest_of(int i);
    return int'(req_dest[i*W +: W]);
  endfunction

  function automatic logic [N*W-1:0] msel(logic [N*W-1:0] s, logic [N-1:0] v);
    for (int o = 0; o < N; o++)
      if (!v[o]) s[o*W +: W] = '0;
    return s;
  endfunction

  task automatic model_reset();
    for (int o = 0; o < N; o++) begin
      m_lock[o] = -1;
      m_ptr[o]  = N - 1;
    end
  endtask

  task automatic model_comb();
    exp_grant = '0; exp_vld = '0; exp_xfer = '0; exp_sel = '0;
    for (int o = 0; o < N; o++) begin
      if (m_lock[o] >= 0) begin
        exp_vld[o]         = 1'b1;
        exp_sel[o*W +: W]  = W'(m_lock[o]);
        exp_xfer[o]        = req_valid[m_lock[o]] & out_ready[o];
        if (out_ready[o]) exp_grant[m_lock[o]] = 1'b1;
      end
    end
  endtask

  task automatic model_clock();
    bit busy [N];
    int nl   [N];
    int idx;
    bit found;
    for (int i = 0; i < N; i++) busy[i] = 1'b0;
    for (int o = 0; o < N; o++) if (m_lock[o] >= 0) busy[m_lock[o]] = 1'b1;
    for (int o = 0; o < N; o++) begin
      nl[o] = m_lock[o];
      if (m_lock[o] >= 0) begin
        if (req_valid[m_lock[o]] && out_ready[o] && req_eop[m_lock[o]]) begin
          m_ptr[o] = m_lock[o];
          nl[o]    = -1;
        end
      end else begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          idx = (m_ptr[o] + k) % N;
          if (!found && req_valid[idx] && dest_of(idx) == o && !busy[idx]) begin
            found = 1'b1;
            nl[o] = idx;
          end
        end
      end
    end
    for (int o = 0; o < N; o++) m_lock[o] = nl[o];
  endtask

  task automatic clear_inputs();
    req_valid = '0; req_dest = '0; req_eop = '0;
    for (int i = 0; i < N; i++) begin
      pk_left[i] = 0;
      pk_dest[i] = 0;
    end
  endtask

  task automatic drive_pk(input bit gaps);
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = (pk_left[i] > 0) && (!gaps || $urandom_range(3) != 0);
      req_dest[i*W +: W] = W'(pk_dest[i]);
      req_eop[i]         = (pk_left[i] == 1);
    end
  endtask

  task automatic consume();
    for (int i = 0; i < N; i++)
      if (req_valid[i] && grant[i] && pk_left[i] > 0) pk_left[i]--;
  endtask

  task automatic settle();
    @(negedge clk);
    model_comb();
  endtask

  task automatic advance();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    out_ready = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid = '1; req_dest = '0; req_eop = '1; out_ready = '1;
    @(negedge clk);
    n_cmp++; if (grant !== '0) begin n_fail++; $display("FAIL rst_grant got=%h want=0", grant); end
    n_cmp++; if (out_sel_valid !== '0) begin n_fail++; $display("FAIL rst_sel_valid got=%h want=0", out_sel_valid); end
    n_cmp++; if (out_xfer !== '0) begin n_fail++; $display("FAIL rst_xfer got=%h want=0", out_xfer); end
    n_cmp++; if (out_sel !== '0) begin n_fail++; $display("FAIL rst_out_sel got=%h want=0", out_sel); end
    do_reset();
  endtask

  task automatic test_single_packet();
    logic e;
    do_reset();
    out_ready = '1;
    pk_left[3] = 4; pk_dest[3] = 5;
    for (int c = 0; c < 8; c++) begin
      drive_pk(1'b0);
      settle();
      n_cmp++;
      if ({grant, out_sel_valid, out_xfer} !== {exp_grant, exp_vld, exp_xfer} || msel(out_sel, out_sel_valid) !== msel(exp_sel, exp_vld)) begin
        n_fail++; $display("FAIL t1_model cyc=%0d got g=%h v=%h x=%h s=%h want g=%h v=%h x=%h s=%h", c, grant, out_sel_valid, out_xfer, out_sel, exp_grant, exp_vld, exp_xfer, exp_sel);
      end
      e = (c >= 1 && c <= 4);
      n_cmp++; if (grant[3] !== e) begin n_fail++; $display("FAIL t1_grant3 cyc=%0d got=%b want=%b", c, grant[3], e); end
      if (c >= 1 && c <= 4) begin
        n_cmp++; if (out_sel[5*W +: W] !== W'(3)) begin n_fail++; $display("FAIL t1_sel5 cyc=%0d got=%0d want=3", c, out_sel[5*W +: W]); end
      end
      if (c == 5) begin
        n_cmp++; if (out_sel_valid[5] !== 1'b0) begin n_fail++; $display("FAIL t1_idle5 got=%b want=0", out_sel_valid[5]); end
      end
      consume();
      advance();
    end
  endtask

  task automatic test_rr_order();
    logic [2:0] eg;
    do_reset();
    out_ready = '1;
    for (int i = 0; i < 3; i++) pk_dest[i] = 7;
    for (int c = 0; c < 13; c++) begin
      for (int i = 0; i < 3; i++) pk_left[i] = 1;
      drive_pk(1'b0);
      settle();
      n_cmp++;
      if ({grant, out_sel_valid, out_xfer} !== {exp_grant, exp_vld, exp_xfer} || msel(out_sel, out_sel_valid) !== msel(exp_sel, exp_vld)) begin
        n_fail++; $display("FAIL t2_model cyc=%0d got g=%h v=%h x=%h s=%h want g=%h v=%h x=%h s=%h", c, grant, out_sel_valid, out_xfer, out_sel, exp_grant, exp_vld, exp_xfer, exp_sel);
      end
      eg = (c % 2 == 1) ? 3'(1 << ((c / 2) % 3)) : 3'b000;
      n_cmp++; if (grant[2:0] !== eg) begin n_fail++; $display("FAIL t2_order cyc=%0d got=%b want=%b", c, grant[2:0], eg); end
      consume();
      advance();
    end
  endtask

  task automatic test_wrap();
    int order[$];
    do_reset();
    out_ready = '1;
    pk_dest[13] = 2; pk_dest[0] = 2;
    pk_left[13] = 1;
    for (int c = 0; c < 10; c++) begin
      if (c >= 2) begin pk_left[0] = 1; pk_left[13] = 1; end
      drive_pk(1'b0);
      settle();
      n_cmp++;
      if ({grant, out_sel_valid, out_xfer} !== {exp_grant, exp_vld, exp_xfer} || msel(out_sel, out_sel_valid) !== msel(exp_sel, exp_vld)) begin
        n_fail++; $display("FAIL t3_model cyc=%0d got g=%h v=%h x=%h s=%h want g=%h v=%h x=%h s=%h", c, grant, out_sel_valid, out_xfer, out_sel, exp_grant, exp_vld, exp_xfer, exp_sel);
      end
      if (c >= 2 && grant[0]) order.push_back(0);
      if (c >= 2 && grant[13]) order.push_back(13);
      consume();
      advance();
    end
    n_cmp++;
    if (order.size() < 2 || order[0] != 0 || order[1] != 13) begin
      n_fail++; $display("FAIL t3_wrap got first=%0d second=%0d n=%0d want 0 then 13", (order.size() > 0) ? order[0] : -1, (order.size() > 1) ? order[1] : -1, order.size());
    end
  endtask

  task automatic test_stall();
    int rp [7] = '{1, 1, 0, 0, 1, 1, 1};
    int nx;
    nx = 0;
    do_reset();
    out_ready = '1;
    pk_left[4] = 3; pk_dest[4] = 9;
    for (int c = 0; c < 7; c++) begin
      out_ready[9] = (rp[c] != 0);
      drive_pk(1'b0);
      settle();
      n_cmp++;
      if ({grant, out_sel_valid, out_xfer} !== {exp_grant, exp_vld, exp_xfer} || msel(out_sel, out_sel_valid) !== msel(exp_sel, exp_vld)) begin
        n_fail++; $display("FAIL t4_model cyc=%0d got g=%h v=%h x=%h s=%h want g=%h v=%h x=%h s=%h", c, grant, out_sel_valid, out_xfer, out_sel, exp_grant, exp_vld, exp_xfer, exp_sel);
      end
      if (c >= 1 && c <= 5) begin
        n_cmp++; if (grant[4] !== out_ready[9]) begin n_fail++; $display("FAIL t4_mirror cyc=%0d got=%b want=%b", c, grant[4], out_ready[9]); end
        n_cmp++; if (out_sel_valid[9] !== 1'b1) begin n_fail++; $display("FAIL t4_hold cyc=%0d got=%b want=1", c, out_sel_valid[9]); end
      end
      if (c == 6) begin
        n_cmp++; if (out_sel_valid[9] !== 1'b0) begin n_fail++; $display("FAIL t4_release got=%b want=0", out_sel_valid[9]); end
      end
      if (out_xfer[9] === 1'b1) nx++;
      consume();
      advance();
    end
    n_cmp++; if (nx != 3) begin n_fail++; $display("FAIL t4_xfer_count got=%0d want=3", nx); end
  endtask

  task automatic test_dest_change();
    do_reset();
    out_ready = '1;
    pk_left[6] = 3; pk_dest[6] = 1;
    for (int c = 0; c < 7; c++) begin
      if (c >= 2) pk_dest[6] = 2;
      drive_pk(1'b0);
      settle();
      n_cmp++;
      if ({grant, out_sel_valid, out_xfer} !== {exp_grant, exp_vld, exp_xfer} || msel(out_sel, out_sel_valid) !== msel(exp_sel, exp_vld)) begin
        n_fail++; $display("FAIL t5_model cyc=%0d got g=%h v=%h x=%h s=%h want g=%h v=%h x=%h s=%h", c, grant, out_sel_valid, out_xfer, out_sel, exp_grant, exp_vld, exp_xfer, exp_sel);
      end
      n_cmp++;
      if ((out_sel_valid[2] && out_sel[2*W +: W] == W'(6)) !== 1'b0) begin
        n_fail++; $display("FAIL t5_out2_took6 cyc=%0d got sel2=%0d vld2=%b", c, out_sel[2*W +: W], out_sel_valid[2]);
      end
      if (c >= 1 && c <= 3) begin
        n_cmp++;
        if ({out_sel_valid[1], out_sel[1*W +: W]} !== {1'b1, W'(6)}) begin
          n_fail++; $display("FAIL t5_lock1 cyc=%0d got vld=%b sel=%0d want vld=1 sel=6", c, out_sel_valid[1], out_sel[1*W +: W]);
        end
      end
      consume();
      advance();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = '1;
    pk_left[0] = 4; pk_dest[0] = 3;
    pk_left[5] = 4; pk_dest[5] = 8;
    for (int c = 0; c < 3; c++) begin
      drive_pk(1'b0);
      settle();
      n_cmp++;
      if ({grant, out_sel_valid, out_xfer} !== {exp_grant, exp_vld, exp_xfer} || msel(out_sel, out_sel_valid) !== msel(exp_sel, exp_vld)) begin
        n_fail++; $display("FAIL t6_model cyc=%0d got g=%h v=%h x=%h s=%h want g=%h v=%h x=%h s=%h", c, grant, out_sel_valid, out_xfer, out_sel, exp_grant, exp_vld, exp_xfer, exp_sel);
      end
      consume();
      advance();
    end
    drive_pk(1'b0);
    rst = 1'b0;
    #1;
    n_cmp++; if (grant !== '0) begin n_fail++; $display("FAIL t6_async_grant got=%h want=0", grant); end
    n_cmp++; if (out_sel_valid !== '0) begin n_fail++; $display("FAIL t6_async_vld got=%h want=0", out_sel_valid); end
    n_cmp++; if (out_xfer !== '0) begin n_fail++; $display("FAIL t6_async_xfer got=%h want=0", out_xfer); end
    model_reset();
    clear_inputs();
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    pk_left[1] = 1; pk_dest[1] = 4;
    pk_left[0] = 1; pk_dest[0] = 4;
    for (int c = 0; c < 5; c++) begin
      drive_pk(1'b0);
      settle();
      n_cmp++;
      if ({grant, out_sel_valid, out_xfer} !== {exp_grant, exp_vld, exp_xfer} || msel(out_sel, out_sel_valid) !== msel(exp_sel, exp_vld)) begin
        n_fail++; $display("FAIL t6b_model cyc=%0d got g=%h v=%h x=%h s=%h want g=%h v=%h x=%h s=%h", c, grant, out_sel_valid, out_xfer, out_sel, exp_grant, exp_vld, exp_xfer, exp_sel);
      end
      if (c == 1) begin
        n_cmp++; if (grant[1:0] !== 2'b01) begin n_fail++; $display("FAIL t6_first_winner got=%b want=01", grant[1:0]); end
      end
      consume();
      advance();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      for (int o = 0; o < N; o++) out_ready[o] = ($urandom_range(3) != 0);
      for (int i = 0; i < N; i++) begin
        if (pk_left[i] == 0 && $urandom_range(2) == 0) begin
          pk_left[i] = 1 + int'($urandom_range(3));
          pk_dest[i] = int'($urandom_range(N - 1));
        end
      end
      drive_pk(1'b1);
      settle();
      n_cmp++;
      if ({grant, out_sel_valid, out_xfer} !== {exp_grant, exp_vld, exp_xfer} || msel(out_sel, out_sel_valid) !== msel(exp_sel, exp_vld)) begin
        n_fail++; $display("FAIL rand_model cyc=%0d got g=%h v=%h x=%h s=%h want g=%h v=%h x=%h s=%h", c, grant, out_sel_valid, out_xfer, out_sel, exp_grant, exp_vld, exp_xfer, exp_sel);
      end
      consume();
      advance();
    end
  endtask

  initial begin
    clear_inputs();
    model_reset();
    test_reset();
    test_single_packet();
    test_rr_order();
    test_wrap();
    test_stall();
    test_dest_change();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
